// File: rtl/div_unit.sv
// Multi-cycle 32-bit DIV/DIVU unit: restoring radix-2 divider, one quotient bit per cycle.
// result = {remainder, quotient}; a zero divisor returns {dividend, all-ones} without iterating.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        annul,
  input  logic        signed_div,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        ready,
  output logic        stall
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIVZERO,
    S_ON,
    S_END
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [64:0] r_work;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic        r_neg_q;
  logic        r_neg_r;
  logic [4:0]  r_cnt;
  logic [63:0] r_result;

  logic        w_go;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [64:0] w_shift;
  logic [32:0] w_diff;
  logic [64:0] w_step;
  logic [31:0] w_quot;
  logic [31:0] w_rem;

  assign w_go    = start & ~annul;
  assign w_a_mag = (signed_div & a[31]) ? (~a + 32'd1) : a;
  assign w_b_mag = (signed_div & b[31]) ? (~b + 32'd1) : b;

  // Remainder lives in bits [64:32], quotient shifts in at bit 0.
  assign w_shift = r_work << 1;
  assign w_diff  = w_shift[64:32] - {1'b0, r_b};
  assign w_step  = w_diff[32] ? w_shift : {w_diff, w_shift[31:1], 1'b1};
  assign w_quot  = r_neg_q ? (~w_step[31:0] + 32'd1)  : w_step[31:0];
  assign w_rem   = r_neg_r ? (~w_step[63:32] + 32'd1) : w_step[63:32];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_go) w_next = (b == 32'd0) ? S_DIVZERO : S_ON;
      S_DIVZERO: w_next = S_END;
      S_ON:      if (r_cnt == 5'd31) w_next = S_END;
      S_END:     w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
    if (annul) w_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_work   <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_go) begin
            r_a     <= a;
            r_b     <= w_b_mag;
            r_work  <= {33'd0, w_a_mag};
            r_neg_q <= signed_div & (a[31] ^ b[31]);
            r_neg_r <= signed_div & a[31];
            r_cnt   <= '0;
          end
        end
        S_DIVZERO: begin
          if (!annul) r_result <= {r_a, 32'hFFFF_FFFF};
        end
        S_ON: begin
          r_work <= w_step;
          r_cnt  <= r_cnt + 5'd1;
          if (!annul && r_cnt == 5'd31) r_result <= {w_rem, w_quot};
        end
        default: ;
      endcase
    end
  end

  assign result = r_result;
  assign ready  = (r_state == S_END) & ~annul;
  assign stall  = start & ~ready & ~annul;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: latency, signed/unsigned results,
// divide-by-zero, annul, mid-division reset and back-to-back starts.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        annul;
  logic        signed_div;
  logic [31:0] a;
  logic [31:0] b;
  logic [63:0] result;
  logic        ready;
  logic        stall;

  int n_checks = 0;
  int n_fail   = 0;

  div_unit dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .annul      (annul),
    .signed_div (signed_div),
    .a          (a),
    .b          (b),
    .result     (result),
    .ready      (ready),
    .stall      (stall)
  );

  always #5 clk = ~clk;

  // Issues one request at the next falling edge (cycle T) and waits for ready.
  // lat is the cycle offset of the ready pulse relative to T, -1 if it never came.
  task automatic run_div(input logic [31:0] ia, input logic [31:0] ib, input logic isg,
                         input bit scramble, input bit hold,
                         output int lat, output logic [63:0] res, output bit stall_ok);
    lat      = -1;
    res      = '0;
    stall_ok = 1'b1;
    @(negedge clk);
    a = ia; b = ib; signed_div = isg; start = 1'b1; annul = 1'b0;
    #1;
    if (stall !== 1'b1 || ready !== 1'b0) stall_ok = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        lat = n;
        res = result;
        if (stall !== 1'b0) stall_ok = 1'b0;
        if (!hold) start = 1'b0;
        break;
      end
      if (stall !== 1'b1) stall_ok = 1'b0;
      if (scramble && n == 5) begin
        a = ~ia; b = ib + 32'd3; signed_div = ~isg;
      end
    end
    if (lat < 0) start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", ready); end
    n_checks++;
    if (result !== 64'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", result); end
    n_checks++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall); end
    rst = 1'b0;
  endtask

  task automatic test_divu();
    logic [31:0] va [5] = '{32'd100, 32'hFFFF_FFFF, 32'd1000, 32'd5, 32'hFFFF_FFF9};
    logic [31:0] vb [5] = '{32'd7, 32'd1, 32'd10, 32'd9, 32'd2};
    logic [63:0] vr [5] = '{{32'd2, 32'd14}, {32'd0, 32'hFFFF_FFFF}, {32'd0, 32'd100},
                            {32'd5, 32'd0}, {32'd1, 32'h7FFF_FFFC}};
    int lat; logic [63:0] res; bit sok;
    for (int i = 0; i < 5; i++) begin
      run_div(va[i], vb[i], 1'b0, 1'b0, 1'b0, lat, res, sok);
      n_checks++;
      if (lat != 33) begin n_fail++; $display("FAIL divu_latency[%0d]: got %0d expected 33", i, lat); end
      n_checks++;
      if (res !== vr[i]) begin n_fail++; $display("FAIL divu_result[%0d]: got %h expected %h", i, res, vr[i]); end
      n_checks++;
      if (!sok) begin n_fail++; $display("FAIL divu_stall[%0d]: got bad-window expected high T..T+32", i); end
    end
  endtask

  task automatic test_div_signed();
    logic [31:0] va [4] = '{32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFF9, 32'd20};
    logic [31:0] vb [4] = '{32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd6};
    logic [63:0] vr [4] = '{{32'hFFFF_FFFF, 32'hFFFF_FFFD}, {32'd1, 32'hFFFF_FFFD},
                            {32'hFFFF_FFFF, 32'd3}, {32'd2, 32'd3}};
    int lat; logic [63:0] res; bit sok;
    for (int i = 0; i < 4; i++) begin
      run_div(va[i], vb[i], 1'b1, 1'b0, 1'b0, lat, res, sok);
      n_checks++;
      if (lat != 33 || res !== vr[i]) begin
        n_fail++;
        $display("FAIL div_signed[%0d]: got lat=%0d res=%h expected lat=33 res=%h", i, lat, res, vr[i]);
      end
    end
  endtask

  task automatic test_overflow();
    int lat; logic [63:0] res; bit sok;
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, lat, res, sok);
    n_checks++;
    if (res !== {32'h0, 32'h8000_0000}) begin n_fail++; $display("FAIL overflow_div: got %h expected %h", res, {32'h0, 32'h8000_0000}); end
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, lat, res, sok);
    n_checks++;
    if (res !== {32'h8000_0000, 32'h0}) begin n_fail++; $display("FAIL overflow_divu: got %h expected %h", res, {32'h8000_0000, 32'h0}); end
  endtask

  task automatic test_divzero();
    int lat; logic [63:0] res; bit sok;
    run_div(32'h1234, 32'h0, 1'b0, 1'b0, 1'b0, lat, res, sok);
    n_checks++;
    if (lat != 2) begin n_fail++; $display("FAIL divzero_latency: got %0d expected 2", lat); end
    n_checks++;
    if (res !== {32'h1234, 32'hFFFF_FFFF}) begin n_fail++; $display("FAIL divzero_result: got %h expected %h", res, {32'h1234, 32'hFFFF_FFFF}); end
    n_checks++;
    if (!sok) begin n_fail++; $display("FAIL divzero_stall: got bad-window expected high T..T+1"); end
    run_div(32'hFFFF_FFFB, 32'h0, 1'b1, 1'b0, 1'b0, lat, res, sok);
    n_checks++;
    if (lat != 2 || res !== {32'hFFFF_FFFB, 32'hFFFF_FFFF}) begin
      n_fail++;
      $display("FAIL divzero_signed: got lat=%0d res=%h expected lat=2 res=%h", lat, res, {32'hFFFF_FFFB, 32'hFFFF_FFFF});
    end
  endtask

  task automatic test_result_hold();
    int lat; logic [63:0] res; bit sok; bit bad;
    run_div(32'd50, 32'd5, 1'b0, 1'b0, 1'b0, lat, res, sok);
    bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ready !== 1'b0 || result !== {32'd0, 32'd10}) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin n_fail++; $display("FAIL result_hold: got ready=%b res=%h expected ready=0 res=%h", ready, result, {32'd0, 32'd10}); end
  endtask

  task automatic test_operand_ignore();
    int lat; logic [63:0] res; bit sok;
    run_div(32'd100, 32'd7, 1'b0, 1'b1, 1'b0, lat, res, sok);
    n_checks++;
    if (lat != 33 || res !== {32'd2, 32'd14}) begin
      n_fail++; $display("FAIL ignore_divu: got lat=%0d res=%h expected lat=33 res=%h", lat, res, {32'd2, 32'd14});
    end
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 1'b0, lat, res, sok);
    n_checks++;
    if (lat != 33 || res !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
      n_fail++; $display("FAIL ignore_div: got lat=%0d res=%h expected lat=33 res=%h", lat, res, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    end
  endtask

  task automatic test_annul();
    int lat; logic [63:0] res; bit sok; bit bad;
    run_div(32'd50, 32'd5, 1'b0, 1'b0, 1'b0, lat, res, sok);
    @(negedge clk);
    a = 32'd999; b = 32'd4; signed_div = 1'b0; start = 1'b1;
    bad = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      if (ready !== 1'b0) bad = 1'b1;
    end
    @(negedge clk);
    annul = 1'b1;
    #1;
    n_checks++;
    if (stall !== 1'b0 || ready !== 1'b0) begin n_fail++; $display("FAIL annul_outputs: got stall=%b ready=%b expected 0 0", stall, ready); end
    @(negedge clk);
    annul = 1'b0; start = 1'b0;
    if (ready !== 1'b0) bad = 1'b1;
    n_checks++;
    if (bad) begin n_fail++; $display("FAIL annul_no_ready: got ready pulse expected none"); end
    n_checks++;
    if (result !== {32'd0, 32'd10}) begin n_fail++; $display("FAIL annul_result: got %h expected %h", result, {32'd0, 32'd10}); end
    run_div(32'd1000, 32'd3, 1'b0, 1'b0, 1'b0, lat, res, sok);
    n_checks++;
    if (lat != 33 || res !== {32'd1, 32'd333}) begin
      n_fail++; $display("FAIL annul_restart: got lat=%0d res=%h expected lat=33 res=%h", lat, res, {32'd1, 32'd333});
    end
    @(negedge clk);
    a = 32'd9; b = 32'd3; start = 1'b1; annul = 1'b1;
    #1;
    n_checks++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL annul_priority_stall: got %b expected 0", stall); end
    @(negedge clk);
    start = 1'b0; annul = 1'b0;
    bad = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ready !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad || result !== {32'd1, 32'd333}) begin
      n_fail++; $display("FAIL annul_priority: got ready_seen=%b res=%h expected 0 %h", bad, result, {32'd1, 32'd333});
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic [63:0] res; bit sok; bit bad;
    @(negedge clk);
    a = 32'd500; b = 32'd7; signed_div = 1'b0; start = 1'b1;
    repeat (19) @(negedge clk);
    @(negedge clk);
    rst = 1'b1; start = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ready !== 1'b0 || result !== 64'h0 || stall !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid: got ready=%b res=%h stall=%b expected 0 0 0", ready, result, stall);
    end
    rst = 1'b0;
    bad = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ready !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin n_fail++; $display("FAIL reset_mid_no_ready: got ready pulse expected none"); end
    run_div(32'd500, 32'd7, 1'b0, 1'b0, 1'b0, lat, res, sok);
    n_checks++;
    if (lat != 33 || res !== {32'd3, 32'd71}) begin
      n_fail++; $display("FAIL reset_mid_restart: got lat=%0d res=%h expected lat=33 res=%h", lat, res, {32'd3, 32'd71});
    end
  endtask

  task automatic test_back_to_back();
    int lat; int lat2; logic [63:0] res; bit sok;
    run_div(32'd100, 32'd7, 1'b0, 1'b0, 1'b1, lat, res, sok);
    n_checks++;
    if (lat != 33 || res !== {32'd2, 32'd14}) begin
      n_fail++; $display("FAIL b2b_first: got lat=%0d res=%h expected lat=33 res=%h", lat, res, {32'd2, 32'd14});
    end
    a = 32'd45; b = 32'd4;
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b1 || ready !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_stall: got stall=%b ready=%b expected 1 0", stall, ready); end
    lat2 = -1;
    for (int n = 2; n <= 40; n++) begin
      @(negedge clk);
      if (ready === 1'b1) begin lat2 = n; break; end
    end
    start = 1'b0;
    n_checks++;
    if (lat2 != 34 || result !== {32'd1, 32'd11}) begin
      n_fail++; $display("FAIL b2b_second: got lat=%0d res=%h expected lat=34 res=%h", lat2, result, {32'd1, 32'd11});
    end
  endtask

  initial begin
    test_reset();
    test_divu();
    test_div_signed();
    test_overflow();
    test_divzero();
    test_result_hold();
    test_operand_ignore();
    test_annul();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
